// File: rtl/conv_dat_wr_ctrl_pkg.sv
// conv_dat_wr_ctrl_pkg
// Width constants shared by the DMA-to-CONV_BUF data write controller and its
// bench. The values mirror the CNN_defines.vh macros so every width is
// defined in one place:
//   BASE_TIN      channels packed into one stream beat
//   MAX_DAT_DW    bits per channel element
//   LOG2_BUF_DEP  CONV_BUF address width
//   LOG2_W/H/CH   widths of the row-width, row-count and slice-count fields
package conv_dat_wr_ctrl_pkg;

    localparam int BASE_TIN     = 4;
    localparam int MAX_DAT_DW   = 8;
    localparam int LOG2_BUF_DEP = 12;
    localparam int LOG2_W       = 8;
    localparam int LOG2_H       = 8;
    localparam int LOG2_CH      = 6;

endpackage

// File: rtl/conv_dat_wr_ctrl.sv
// conv_dat_wr_ctrl
// Accepts the input feature-map tensor from the DMA read engine as an
// AXI-stream and writes it beat by beat into CONV_BUF. The buffer address is
// slice_base + h*Win + w, kept incrementally, so no multiplier is needed.
// Row and slice completion are reported one cycle after the matching write
// lands, so a consumer never sees a row before its data is in the buffer.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   fsm_logic_init                   start pulse, latches the config inputs
//   Win, Hin, Hin_x_Win              row width, rows per slice, beats per slice
//   ch_slice_num                     number of channel slices (a count)
//   dma_dat_reuse                    tensor already buffered, skip streaming
//   s_dat_tvalid/tready/tdata/tlast  input stream from the DMA
//   buf_full                         buffer credit backpressure
//   dma2buf_DAT_wr_en/addr/data      CONV_BUF write port
//   row_num_updt, row_num            rows completed in the current slice
//   chin_num_updt, chin_num          index of the slice just completed
//   dat_done, cfg_err, busy          completion pulse, sticky error, activity
module conv_dat_wr_ctrl
    import conv_dat_wr_ctrl_pkg::*;
#(
    parameter int DW = BASE_TIN * MAX_DAT_DW,
    parameter int AW = LOG2_BUF_DEP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fsm_logic_init,
    input  logic [LOG2_W-1:0]        Win,
    input  logic [LOG2_H-1:0]        Hin,
    input  logic [LOG2_W+LOG2_H-1:0] Hin_x_Win,
    input  logic [LOG2_CH-1:0]       ch_slice_num,
    input  logic                     dma_dat_reuse,
    input  logic                     s_dat_tvalid,
    output logic                     s_dat_tready,
    input  logic [DW-1:0]            s_dat_tdata,
    input  logic                     s_dat_tlast,
    input  logic                     buf_full,
    output logic                     dma2buf_DAT_wr_en,
    output logic [AW-1:0]            dma2buf_DAT_wr_addr,
    output logic [DW-1:0]            dma2buf_DAT_wr_data,
    output logic                     row_num_updt,
    output logic [LOG2_H-1:0]        row_num,
    output logic                     chin_num_updt,
    output logic [LOG2_CH-1:0]       chin_num,
    output logic                     dat_done,
    output logic                     cfg_err,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int HW_W = LOG2_W + LOG2_H;
    // The slice base is kept at least as wide as the slice step so that every
    // step bit takes part in the sum; the address is its low AW bits.
    localparam int BW   = (AW > HW_W) ? AW : HW_W;

    state_t                state_q, state_d;

    logic [LOG2_W-1:0]     win_r;
    logic [LOG2_H-1:0]     hin_r;
    logic [HW_W-1:0]       hw_r;
    logic [LOG2_CH-1:0]    ch_r;
    logic                  reuse_r;

    logic [LOG2_W-1:0]     w_q;
    logic [LOG2_H-1:0]     h_q;
    logic [LOG2_CH-1:0]    slice_q;
    logic [AW-1:0]         addr_q;
    logic [BW-1:0]         base_q;
    logic [BW-1:0]         next_base;

    logic                  row_end_d, slice_end_d;
    logic [LOG2_H-1:0]     row_num_d;
    logic [LOG2_CH-1:0]    chin_num_d;

    logic                  init_take, zero_cfg, accept;
    logic                  last_w, last_h, last_slice, last_beat, reuse_done;

    assign zero_cfg   = (Win == '0) || (Hin == '0) || (ch_slice_num == '0);
    assign init_take  = (state_q == ST_IDLE) && fsm_logic_init;
    assign s_dat_tready = (state_q == ST_RUN) && !buf_full;
    assign accept     = s_dat_tready && s_dat_tvalid;
    assign busy       = (state_q != ST_IDLE);

    assign last_w     = (w_q == win_r - LOG2_W'(1));
    assign last_h     = (h_q == hin_r - LOG2_H'(1));
    assign last_slice = (slice_q == ch_r - LOG2_CH'(1));
    assign last_beat  = last_w && last_h && last_slice;
    assign next_base  = base_q + BW'(hw_r);
    // On the reuse path nothing is streamed, so the completion reports are
    // synthesised from the latched config as the controller leaves DONE.
    assign reuse_done = (state_q == ST_DONE) && reuse_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Bad config and reuse both skip streaming and go
    // straight to DONE so the completion pulse is still produced.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fsm_logic_init) begin
                    state_d = (zero_cfg || dma_dat_reuse) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Config latch and the sticky error flag. A tlast that disagrees with
    // the counters is only reported; the counters still decide termination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r   <= '0;
            hin_r   <= '0;
            hw_r    <= '0;
            ch_r    <= '0;
            reuse_r <= 1'b0;
            cfg_err <= 1'b0;
        end else if (init_take) begin
            win_r   <= Win;
            hin_r   <= Hin;
            hw_r    <= Hin_x_Win;
            ch_r    <= ch_slice_num;
            reuse_r <= dma_dat_reuse && !zero_cfg;
            cfg_err <= zero_cfg;
        end else if (accept && (s_dat_tlast != last_beat)) begin
            cfg_err <= 1'b1;
        end
    end

    // Nested w/h/slice counters and the incremental write address. At a
    // slice boundary the address is reloaded from the slice base so that
    // Hin_x_Win governs the slice pitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            h_q     <= '0;
            slice_q <= '0;
            addr_q  <= '0;
            base_q  <= '0;
        end else if (init_take) begin
            w_q     <= '0;
            h_q     <= '0;
            slice_q <= '0;
            addr_q  <= '0;
            base_q  <= '0;
        end else if (accept) begin
            if (!last_w) begin
                w_q    <= w_q + LOG2_W'(1);
                addr_q <= addr_q + AW'(1);
            end else if (!last_h) begin
                w_q    <= '0;
                h_q    <= h_q + LOG2_H'(1);
                addr_q <= addr_q + AW'(1);
            end else begin
                w_q     <= '0;
                h_q     <= '0;
                slice_q <= slice_q + LOG2_CH'(1);
                base_q  <= next_base;
                addr_q  <= AW'(next_base);
            end
        end
    end

    // First pipeline stage: register the accepted beat as a buffer write and
    // remember whether it closed a row or a slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma2buf_DAT_wr_en   <= 1'b0;
            dma2buf_DAT_wr_addr <= '0;
            dma2buf_DAT_wr_data <= '0;
            row_end_d           <= 1'b0;
            slice_end_d         <= 1'b0;
            row_num_d           <= '0;
            chin_num_d          <= '0;
        end else begin
            dma2buf_DAT_wr_en <= accept;
            row_end_d         <= accept && last_w;
            slice_end_d       <= accept && last_w && last_h;
            if (accept) begin
                dma2buf_DAT_wr_addr <= addr_q;
                dma2buf_DAT_wr_data <= s_dat_tdata;
                row_num_d           <= h_q + LOG2_H'(1);
                chin_num_d          <= slice_q;
            end
        end
    end

    // Second pipeline stage: completion reports trail the write by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_num_updt  <= 1'b0;
            row_num       <= '0;
            chin_num_updt <= 1'b0;
            chin_num      <= '0;
            dat_done      <= 1'b0;
        end else begin
            row_num_updt  <= row_end_d || reuse_done;
            chin_num_updt <= slice_end_d || reuse_done;
            dat_done      <= (state_q == ST_DONE);
            if (row_end_d) begin
                row_num <= row_num_d;
            end else if (reuse_done) begin
                row_num <= hin_r;
            end
            if (slice_end_d) begin
                chin_num <= chin_num_d;
            end else if (reuse_done) begin
                chin_num <= ch_r - LOG2_CH'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_dat_wr_ctrl.sv
// tb_conv_dat_wr_ctrl
// Drives conv_dat_wr_ctrl through streaming, backpressure, reuse, bad config,
// mid-run reset, tlast mismatch and back-to-back runs. Expected writes are
// queued when a beat is accepted and popped when the write port fires.
module tb_conv_dat_wr_ctrl;
    import conv_dat_wr_ctrl_pkg::*;

    localparam int DW = BASE_TIN * MAX_DAT_DW;
    localparam int AW = LOG2_BUF_DEP;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [DW-1:0]      data;
        bit                 row_end;
        logic [LOG2_H-1:0]  row_val;
        bit                 slice_end;
        logic [LOG2_CH-1:0] chin;
        bit                 final_b;
    } wr_exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     fsm_logic_init = 1'b0;
    logic [LOG2_W-1:0]        Win = '0;
    logic [LOG2_H-1:0]        Hin = '0;
    logic [LOG2_W+LOG2_H-1:0] Hin_x_Win = '0;
    logic [LOG2_CH-1:0]       ch_slice_num = '0;
    logic                     dma_dat_reuse = 1'b0;
    logic                     s_dat_tvalid = 1'b0;
    logic                     s_dat_tready;
    logic [DW-1:0]            s_dat_tdata = '0;
    logic                     s_dat_tlast = 1'b0;
    logic                     buf_full = 1'b0;
    logic                     dma2buf_DAT_wr_en;
    logic [AW-1:0]            dma2buf_DAT_wr_addr;
    logic [DW-1:0]            dma2buf_DAT_wr_data;
    logic                     row_num_updt;
    logic [LOG2_H-1:0]        row_num;
    logic                     chin_num_updt;
    logic [LOG2_CH-1:0]       chin_num;
    logic                     dat_done;
    logic                     cfg_err;
    logic                     busy;

    int n_tests = 0;
    int n_fail  = 0;
    wr_exp_t exp_q[$];
    bit strict = 1'b0;
    bit pend_row = 1'b0, pend_slice = 1'b0, pend_done = 1'b0;
    logic [LOG2_H-1:0]  pend_row_val = '0;
    logic [LOG2_CH-1:0] pend_chin = '0;
    int wr_count = 0, row_count = 0, chin_count = 0, done_count = 0;

    conv_dat_wr_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fsm_logic_init      (fsm_logic_init),
        .Win                 (Win),
        .Hin                 (Hin),
        .Hin_x_Win           (Hin_x_Win),
        .ch_slice_num        (ch_slice_num),
        .dma_dat_reuse       (dma_dat_reuse),
        .s_dat_tvalid        (s_dat_tvalid),
        .s_dat_tready        (s_dat_tready),
        .s_dat_tdata         (s_dat_tdata),
        .s_dat_tlast         (s_dat_tlast),
        .buf_full            (buf_full),
        .dma2buf_DAT_wr_en   (dma2buf_DAT_wr_en),
        .dma2buf_DAT_wr_addr (dma2buf_DAT_wr_addr),
        .dma2buf_DAT_wr_data (dma2buf_DAT_wr_data),
        .row_num_updt        (row_num_updt),
        .row_num             (row_num),
        .chin_num_updt       (chin_num_updt),
        .chin_num            (chin_num),
        .dat_done            (dat_done),
        .cfg_err             (cfg_err),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pops an expected write for every write-port cycle
    // and, in strict mode, demands that row/slice/done reports follow the
    // write that closed them by exactly one cycle.
    always @(posedge clk) begin
        wr_exp_t e;
        #2;
        if (!rst_n) begin
            pend_row = 1'b0; pend_slice = 1'b0; pend_done = 1'b0;
        end else begin
            if (strict) begin
                n_tests++;
                if (row_num_updt !== pend_row) begin
                    n_fail++;
                    $display("[TB] FAIL row_updt_timing got %b want %b at %0t", row_num_updt, pend_row, $time);
                end
                if (pend_row) begin
                    n_tests++;
                    if (row_num !== pend_row_val) begin
                        n_fail++;
                        $display("[TB] FAIL row_num got %0d want %0d", row_num, pend_row_val);
                    end
                end
                n_tests++;
                if (chin_num_updt !== pend_slice) begin
                    n_fail++;
                    $display("[TB] FAIL chin_updt_timing got %b want %b at %0t", chin_num_updt, pend_slice, $time);
                end
                if (pend_slice) begin
                    n_tests++;
                    if (chin_num !== pend_chin) begin
                        n_fail++;
                        $display("[TB] FAIL chin_num got %0d want %0d", chin_num, pend_chin);
                    end
                end
                n_tests++;
                if (dat_done !== pend_done) begin
                    n_fail++;
                    $display("[TB] FAIL dat_done_timing got %b want %b at %0t", dat_done, pend_done, $time);
                end
            end
            pend_row = 1'b0; pend_slice = 1'b0; pend_done = 1'b0;
            if (row_num_updt === 1'b1) row_count++;
            if (chin_num_updt === 1'b1) chin_count++;
            if (dat_done === 1'b1) done_count++;
            if (dma2buf_DAT_wr_en === 1'b1) begin
                wr_count++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_write addr %0d, no write expected", dma2buf_DAT_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (dma2buf_DAT_wr_addr !== e.addr || dma2buf_DAT_wr_data !== e.data) begin
                        n_fail++;
                        $display("[TB] FAIL write got addr %0d data %h want addr %0d data %h",
                                 dma2buf_DAT_wr_addr, dma2buf_DAT_wr_data, e.addr, e.data);
                    end
                    pend_row     = e.row_end;
                    pend_row_val = e.row_val;
                    pend_slice   = e.slice_end;
                    pend_chin    = e.chin;
                    pend_done    = e.final_b;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_counts();
        wr_count = 0; row_count = 0; chin_count = 0; done_count = 0;
    endtask

    // Starts a streaming run and feeds beats until the bench model sees the
    // final beat accepted. Optional buf_full window, tvalid gaps, an ignored
    // init pulse mid-run, and an abort by reset after a given beat count.
    task automatic run_stream(input int win, input int hin, input int ch,
                              input int bf_lo, input int bf_hi, input int tlast_idx,
                              input bit gaps, input bit poke_init, input int abort_after);
        int total, beat, cyc, w, h, s;
        bit running, aborted;
        wr_exp_t e;
        total = win * hin * ch;
        @(negedge clk);
        Win = LOG2_W'(win); Hin = LOG2_H'(hin);
        Hin_x_Win = (LOG2_W+LOG2_H)'(win * hin);
        ch_slice_num = LOG2_CH'(ch); dma_dat_reuse = 1'b0; fsm_logic_init = 1'b1;
        @(negedge clk);
        fsm_logic_init = 1'b0;
        running = 1'b1; aborted = 1'b0;
        beat = 0; w = 0; h = 0; s = 0; cyc = 0;
        while (running && cyc < 500) begin
            if (abort_after >= 0 && beat == abort_after) begin
                rst_n = 1'b0;
                aborted = 1'b1;
                break;
            end
            buf_full = (cyc >= bf_lo) && (cyc <= bf_hi);
            s_dat_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_dat_tdata = DW'($urandom());
            s_dat_tlast = (beat == tlast_idx);
            if (poke_init && cyc == 3) begin
                fsm_logic_init = 1'b1; Win = '0;
            end else begin
                fsm_logic_init = 1'b0; Win = LOG2_W'(win);
            end
            #1;
            n_tests++;
            if (s_dat_tready !== !buf_full) begin
                n_fail++;
                $display("[TB] FAIL tready cyc %0d got %b want %b", cyc, s_dat_tready, !buf_full);
            end
            if (s_dat_tvalid && !buf_full) begin
                e.addr      = AW'(s * win * hin + h * win + w);
                e.data      = s_dat_tdata;
                e.row_end   = (w == win - 1);
                e.row_val   = LOG2_H'(h + 1);
                e.slice_end = (w == win - 1) && (h == hin - 1);
                e.chin      = LOG2_CH'(s);
                e.final_b   = (beat == total - 1);
                exp_q.push_back(e);
                beat++;
                if (++w == win) begin
                    w = 0;
                    if (++h == hin) begin h = 0; s++; end
                end
                if (beat == total) running = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        if (aborted) return;
        if (running) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL stream_timeout got %0d beats want %0d", beat, total);
        end
        s_dat_tvalid = 1'b0; s_dat_tlast = 1'b0; buf_full = 1'b0; fsm_logic_init = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({dma2buf_DAT_wr_en, s_dat_tready, busy, cfg_err, dat_done, row_num_updt, chin_num_updt} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got %b want 0000000",
                     {dma2buf_DAT_wr_en, s_dat_tready, busy, cfg_err, dat_done, row_num_updt, chin_num_updt});
        end
        n_tests++;
        if (dma2buf_DAT_wr_addr !== '0 || row_num !== '0 || chin_num !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_values got addr %0d row %0d chin %0d want 0", dma2buf_DAT_wr_addr, row_num, chin_num);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_counts();
        strict = 1'b1;
        run_stream(4, 2, 2, -1, -1, 15, 1'b0, 1'b0, -1);
        n_tests++;
        if (wr_count != 16 || row_count != 4 || chin_count != 2 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL basic_counts got wr %0d row %0d chin %0d done %0d want 16 4 2 1", wr_count, row_count, chin_count, done_count);
        end
        n_tests++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL basic_end got cfg_err %b busy %b pending %0d want 0 0 0", cfg_err, busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        clear_counts();
        run_stream(4, 2, 2, 3, 6, 15, 1'b0, 1'b0, -1);
        n_tests++;
        if (wr_count != 16 || row_count != 4 || chin_count != 2 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL bp_counts got wr %0d row %0d chin %0d done %0d want 16 4 2 1", wr_count, row_count, chin_count, done_count);
        end
    endtask

    task automatic test_reuse();
        clear_counts();
        strict = 1'b0;
        @(negedge clk);
        Win = 8'd4; Hin = 8'd5; Hin_x_Win = 16'd20; ch_slice_num = 6'd3;
        dma_dat_reuse = 1'b1; fsm_logic_init = 1'b1;
        @(negedge clk);
        fsm_logic_init = 1'b0; dma_dat_reuse = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || dat_done !== 1'b0 || s_dat_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reuse_done_state got busy %b done %b tready %b want 1 0 0", busy, dat_done, s_dat_tready);
        end
        @(negedge clk);
        n_tests++;
        if ({dat_done, row_num_updt, chin_num_updt} !== 3'b111 || row_num !== 8'd5 || chin_num !== 6'd2) begin
            n_fail++;
            $display("[TB] FAIL reuse_pulse got %b row %0d chin %0d want 111 row 5 chin 2",
                     {dat_done, row_num_updt, chin_num_updt}, row_num, chin_num);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (wr_count != 0 || done_count != 1 || row_count != 1 || chin_count != 1 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reuse_totals got wr %0d done %0d row %0d chin %0d err %b busy %b want 0 1 1 1 0 0",
                     wr_count, done_count, row_count, chin_count, cfg_err, busy);
        end
        strict = 1'b1;
    endtask

    task automatic test_zero_cfg();
        clear_counts();
        strict = 1'b0;
        @(negedge clk);
        Win = '0; Hin = 8'd2; Hin_x_Win = '0; ch_slice_num = 6'd2;
        fsm_logic_init = 1'b1; s_dat_tvalid = 1'b1;
        @(negedge clk);
        fsm_logic_init = 1'b0;
        n_tests++;
        if (s_dat_tready !== 1'b0 || cfg_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_cfg_state got tready %b err %b busy %b want 0 1 1", s_dat_tready, cfg_err, busy);
        end
        @(negedge clk);
        n_tests++;
        if (dat_done !== 1'b1 || row_num_updt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_cfg_done got done %b row_updt %b want 1 0", dat_done, row_num_updt);
        end
        repeat (3) @(negedge clk);
        s_dat_tvalid = 1'b0;
        n_tests++;
        if (wr_count != 0 || done_count != 1 || cfg_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_cfg_totals got wr %0d done %0d err %b want 0 1 1", wr_count, done_count, cfg_err);
        end
        strict = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int held;
        clear_counts();
        run_stream(4, 2, 2, -1, -1, 15, 1'b0, 1'b0, 5);
        #1;
        n_tests++;
        if ({dma2buf_DAT_wr_en, s_dat_tready, busy, cfg_err, dat_done, row_num_updt, chin_num_updt} !== 7'b0
            || dma2buf_DAT_wr_addr !== '0 || dma2buf_DAT_wr_data !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrun_reset got flags %b addr %0d data %h want all 0",
                     {dma2buf_DAT_wr_en, s_dat_tready, busy, cfg_err, dat_done, row_num_updt, chin_num_updt},
                     dma2buf_DAT_wr_addr, dma2buf_DAT_wr_data);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        held = wr_count;
        repeat (3) @(negedge clk);
        s_dat_tvalid = 1'b0;
        n_tests++;
        if (wr_count != held || s_dat_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_quiet got writes %0d tready %b want %0d 0", wr_count - held, s_dat_tready, 0);
        end
        clear_counts();
        run_stream(4, 2, 2, -1, -1, 15, 1'b0, 1'b0, -1);
        n_tests++;
        if (wr_count != 16 || done_count != 1 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL restart_counts got wr %0d done %0d err %b want 16 1 0", wr_count, done_count, cfg_err);
        end
    endtask

    task automatic test_tlast_early();
        clear_counts();
        run_stream(4, 2, 2, -1, -1, 9, 1'b0, 1'b0, -1);
        n_tests++;
        if (cfg_err !== 1'b1 || wr_count != 16 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL tlast_early got err %b wr %0d done %0d want 1 16 1", cfg_err, wr_count, done_count);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        run_stream(3, 3, 1, -1, -1, 8, 1'b1, 1'b1, -1);
        n_tests++;
        if (cfg_err !== 1'b0 || wr_count != 9 || row_count != 3 || chin_count != 1 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_first got err %b wr %0d row %0d chin %0d done %0d want 0 9 3 1 1",
                     cfg_err, wr_count, row_count, chin_count, done_count);
        end
        clear_counts();
        run_stream(5, 1, 2, -1, -1, 9, 1'b1, 1'b0, -1);
        n_tests++;
        if (cfg_err !== 1'b0 || wr_count != 10 || row_count != 2 || chin_count != 2 || done_count != 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_second got err %b wr %0d row %0d chin %0d done %0d want 0 10 2 2 1",
                     cfg_err, wr_count, row_count, chin_count, done_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reuse();
        test_zero_cfg();
        test_reset_mid_run();
        test_tlast_early();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
